// File: rtl/server_op5_out.sv
// server_op5_out: drain stage behind the op5 server input filter.
//
// Pops beats from the filter's fall-through packet FIFO and re-emits them on
// an AXI4-Stream master through one output register with full backpressure.
// On beat 1 of every packet the UDP source and destination ports are swapped
// (when SWAP_EN=1), which turns the request into a server reply.
//
// Ports:
//   axis_aclk, axis_resetn   clock, asynchronous active-low reset
//   i_pkt_fifo_empty_4       upstream FIFO empty flag
//   o_pkt_fifo_rd_en_4       upstream FIFO pop strobe (combinational)
//   i_t*_fifo_4              FIFO head beat (valid whenever empty=0)
//   m_axis_*                 AXI4-Stream master output
//   o_pkt_cnt, o_beat_cnt    packets / beats accepted downstream (wrapping)
//   o_busy                   high while a packet is part-way through
module server_op5_out #(
    parameter int unsigned C_M_AXIS_DATA_WIDTH  = 256,
    parameter int unsigned C_M_AXIS_TUSER_WIDTH = 128,
    parameter bit          SWAP_EN              = 1'b1
) (
    input  logic                                 axis_aclk,
    input  logic                                 axis_resetn,
    input  logic                                 i_pkt_fifo_empty_4,
    output logic                                 o_pkt_fifo_rd_en_4,
    input  logic [C_M_AXIS_DATA_WIDTH-1:0]       i_tdata_fifo_4,
    input  logic [C_M_AXIS_TUSER_WIDTH-1:0]      i_tuser_fifo_4,
    input  logic [C_M_AXIS_DATA_WIDTH/8-1:0]     i_tkeep_fifo_4,
    input  logic                                 i_tlast_fifo_4,
    output logic [C_M_AXIS_DATA_WIDTH-1:0]       m_axis_tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]     m_axis_tkeep,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]      m_axis_tuser,
    output logic                                 m_axis_tvalid,
    input  logic                                 m_axis_tready,
    output logic                                 m_axis_tlast,
    output logic [31:0]                          o_pkt_cnt,
    output logic [31:0]                          o_beat_cnt,
    output logic                                 o_busy
);

    localparam int unsigned KeepWidth = C_M_AXIS_DATA_WIDTH / 8;

    typedef enum logic [1:0] {StHdr, StPort, StBody} state_e;

    state_e                            state_q, state_d;
    logic                              pop;
    logic                              accept;
    logic [C_M_AXIS_DATA_WIDTH-1:0]    tdata_mod;

    logic [C_M_AXIS_DATA_WIDTH-1:0]    tdata_q;
    logic [C_M_AXIS_TUSER_WIDTH-1:0]   tuser_q;
    logic [KeepWidth-1:0]              tkeep_q;
    logic                              tlast_q;
    logic                              tvalid_q;
    logic [31:0]                       pkt_cnt_q;
    logic [31:0]                       beat_cnt_q;

    // Pop whenever the output register is empty or being drained this cycle.
    assign pop    = !i_pkt_fifo_empty_4 && (!tvalid_q || m_axis_tready);
    assign accept = tvalid_q && m_axis_tready;

    // FSM: state register
    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            state_q <= StHdr;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state, advancing only on a pop so underruns simply hold
    always_comb begin
        state_d = state_q;
        if (pop) begin
            case (state_q)
                StHdr:   state_d = i_tlast_fifo_4 ? StHdr : StPort;
                StPort:  state_d = i_tlast_fifo_4 ? StHdr : StBody;
                StBody:  state_d = i_tlast_fifo_4 ? StHdr : StBody;
                default: state_d = StHdr;
            endcase
        end
    end

    // FSM: outputs
    always_comb begin
        o_pkt_fifo_rd_en_4 = pop;
        o_busy             = (state_q != StHdr);
        tdata_mod          = i_tdata_fifo_4;
        // Beat 1 carries the UDP header ports: src at [63:48], dst at [47:32].
        if (SWAP_EN && (state_q == StPort)) begin
            tdata_mod[47:32] = i_tdata_fifo_4[63:48];
            tdata_mod[63:48] = i_tdata_fifo_4[47:32];
        end
    end

    // Output register: a pop overwrites the current beat even if it is being
    // accepted in the same cycle, giving 1 beat/cycle with no bubble.
    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            tdata_q  <= '0;
            tuser_q  <= '0;
            tkeep_q  <= '0;
            tlast_q  <= 1'b0;
            tvalid_q <= 1'b0;
        end else if (pop) begin
            tdata_q  <= tdata_mod;
            tuser_q  <= i_tuser_fifo_4;
            tkeep_q  <= i_tkeep_fifo_4;
            tlast_q  <= i_tlast_fifo_4;
            tvalid_q <= 1'b1;
        end else if (m_axis_tready) begin
            tvalid_q <= 1'b0;
        end
    end

    // Statistics, counted on the downstream handshake; wrap naturally.
    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            pkt_cnt_q  <= '0;
            beat_cnt_q <= '0;
        end else if (accept) begin
            beat_cnt_q <= beat_cnt_q + 32'd1;
            if (tlast_q) begin
                pkt_cnt_q <= pkt_cnt_q + 32'd1;
            end
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tuser  = tuser_q;
    assign m_axis_tkeep  = tkeep_q;
    assign m_axis_tlast  = tlast_q;
    assign m_axis_tvalid = tvalid_q;
    assign o_pkt_cnt     = pkt_cnt_q;
    assign o_beat_cnt    = beat_cnt_q;

endmodule

// File: tb/tb_server_op5_out.sv
// Bench for server_op5_out: a queue-based FIFO model feeds two DUTs (swap on
// and swap off); the expected output stream is built per packet from beat
// indices and checked on every accepted beat, with per-cycle checks of pop,
// busy, counters and stall stability.
module tb_server_op5_out;

    localparam int DW = 256;
    localparam int UW = 128;
    localparam int KW = 32;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [UW-1:0] u;
        logic [KW-1:0] k;
        logic          l;
    } beat_t;

    logic axis_aclk   = 1'b0;
    logic axis_resetn = 1'b1;
    always #5 axis_aclk = ~axis_aclk;

    logic          fifo_empty = 1'b1;
    logic [DW-1:0] f_tdata    = '0;
    logic [UW-1:0] f_tuser    = '0;
    logic [KW-1:0] f_tkeep    = '0;
    logic          f_tlast    = 1'b0;
    logic          tready     = 1'b1;

    logic          rd_en_a, tvalid_a, tlast_a, busy_a;
    logic [DW-1:0] tdata_a;
    logic [UW-1:0] tuser_a;
    logic [KW-1:0] tkeep_a;
    logic [31:0]   pkt_a, beats_a;

    logic          rd_en_b, tvalid_b, tlast_b, busy_b;
    logic [DW-1:0] tdata_b;
    logic [UW-1:0] tuser_b;
    logic [KW-1:0] tkeep_b;
    logic [31:0]   pkt_b, beats_b;

    server_op5_out #(.C_M_AXIS_DATA_WIDTH(DW), .C_M_AXIS_TUSER_WIDTH(UW), .SWAP_EN(1'b1)) dut (
        .axis_aclk(axis_aclk), .axis_resetn(axis_resetn),
        .i_pkt_fifo_empty_4(fifo_empty), .o_pkt_fifo_rd_en_4(rd_en_a),
        .i_tdata_fifo_4(f_tdata), .i_tuser_fifo_4(f_tuser),
        .i_tkeep_fifo_4(f_tkeep), .i_tlast_fifo_4(f_tlast),
        .m_axis_tdata(tdata_a), .m_axis_tkeep(tkeep_a), .m_axis_tuser(tuser_a),
        .m_axis_tvalid(tvalid_a), .m_axis_tready(tready), .m_axis_tlast(tlast_a),
        .o_pkt_cnt(pkt_a), .o_beat_cnt(beats_a), .o_busy(busy_a)
    );

    server_op5_out #(.C_M_AXIS_DATA_WIDTH(DW), .C_M_AXIS_TUSER_WIDTH(UW), .SWAP_EN(1'b0)) dut_ns (
        .axis_aclk(axis_aclk), .axis_resetn(axis_resetn),
        .i_pkt_fifo_empty_4(fifo_empty), .o_pkt_fifo_rd_en_4(rd_en_b),
        .i_tdata_fifo_4(f_tdata), .i_tuser_fifo_4(f_tuser),
        .i_tkeep_fifo_4(f_tkeep), .i_tlast_fifo_4(f_tlast),
        .m_axis_tdata(tdata_b), .m_axis_tkeep(tkeep_b), .m_axis_tuser(tuser_b),
        .m_axis_tvalid(tvalid_b), .m_axis_tready(tready), .m_axis_tlast(tlast_b),
        .o_pkt_cnt(pkt_b), .o_beat_cnt(beats_b), .o_busy(busy_b)
    );

    int    total = 0;
    int    bad   = 0;
    beat_t fifo[$];
    beat_t exp_q[$];
    beat_t raw_q[$];
    beat_t got[$];
    int    m_beats = 0;
    int    m_pkts  = 0;
    bit    m_inpkt = 1'b0;
    bit    pop_pend = 1'b0;
    bit    stall_q = 1'b0;
    beat_t prev_b;
    int    nstall = 0;
    int    cyc = 0;
    bit    rdy_toggle = 1'b0;

    task automatic chk(input string nm, input logic [416:0] act, input logic [416:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, req);
        end
    endtask

    function automatic beat_t mk_beat(input int id, input int b, input int n);
        beat_t x;
        for (int w = 0; w < 8; w++) begin
            x.d[w*32 +: 32] = {id[7:0], b[7:0], w[7:0], 8'h5A};
        end
        if (id == 1 && b == 1) begin
            x.d[63:48] = 16'h1234;
            x.d[47:32] = 16'h04D2;
        end
        x.u = {4{id[7:0], b[7:0], 16'hC0DE}};
        x.k = (b == n - 1) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
        x.l = (b == n - 1);
        return x;
    endfunction

    // Reply = request with the two 16-bit UDP port fields exchanged.
    function automatic beat_t swp(input beat_t x);
        beat_t y;
        y = x;
        y.d[47:32] = x.d[63:48];
        y.d[63:48] = x.d[47:32];
        return y;
    endfunction

    function automatic beat_t out_a();
        beat_t y;
        y.d = tdata_a; y.u = tuser_a; y.k = tkeep_a; y.l = tlast_a;
        return y;
    endfunction

    function automatic beat_t out_b();
        beat_t y;
        y.d = tdata_b; y.u = tuser_b; y.k = tkeep_b; y.l = tlast_b;
        return y;
    endfunction

    task automatic refresh();
        if (fifo.size() != 0) begin
            fifo_empty = 1'b0;
            f_tdata = fifo[0].d; f_tuser = fifo[0].u;
            f_tkeep = fifo[0].k; f_tlast = fifo[0].l;
        end else begin
            fifo_empty = 1'b1;
        end
    endtask

    task automatic push_beats(input int id, input int from, input int to, input int n);
        beat_t x;
        for (int b = from; b <= to; b++) begin
            x = mk_beat(id, b, n);
            fifo.push_back(x);
            raw_q.push_back(x);
            exp_q.push_back((b == 1) ? swp(x) : x);
        end
        refresh();
    endtask

    task automatic step();
        @(posedge axis_aclk);
        #1;
        if (pop_pend && fifo.size() != 0) void'(fifo.pop_front());
        cyc++;
        tready = rdy_toggle ? ((cyc % 3) == 0) : 1'b1;
        refresh();
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((exp_q.size() != 0 || fifo.size() != 0) && k < 300) begin
            step();
            k++;
        end
        chk("drain_bound", k < 300, 1'b1);
    endtask

    // Per-cycle compare, sampled mid-cycle while inputs and state are stable.
    always @(negedge axis_aclk) begin
        if (!axis_resetn) begin
            pop_pend = 1'b0;
            stall_q  = 1'b0;
        end else begin
            chk("rd_en", rd_en_a, (fifo.size() != 0) && (!tvalid_a || tready));
            chk("rd_en_noswap", rd_en_b, rd_en_a);
            chk("busy", busy_a, m_inpkt);
            chk("beat_cnt", beats_a, m_beats);
            chk("pkt_cnt", pkt_a, m_pkts);
            chk("beat_cnt_noswap", beats_b, m_beats);
            chk("tvalid_noswap", tvalid_b, tvalid_a);
            if (stall_q) begin
                chk("stall_valid", tvalid_a, 1'b1);
                chk("stall_beat", out_a(), prev_b);
            end
            if (tvalid_a && tready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 1'b1, 1'b0);
                end else begin
                    chk("beat", out_a(), exp_q[0]);
                    chk("beat_noswap", out_b(), raw_q[0]);
                    got.push_back(out_a());
                    void'(exp_q.pop_front());
                    void'(raw_q.pop_front());
                end
                m_beats++;
                if (tlast_a) m_pkts++;
            end
            if (tvalid_a && !tready) nstall++;
            stall_q = tvalid_a && !tready;
            prev_b  = out_a();
            pop_pend = rd_en_a;
            if (rd_en_a && fifo.size() != 0) m_inpkt = !fifo[0].l;
        end
    end

    initial begin
        int gb;
        int base_p;
        int base_b;
        int nv;
        int first_v;
        int last_v;
        beat_t x;

        #2 axis_resetn = 1'b0;
        #1;
        chk("rst_tvalid", tvalid_a, 1'b0);
        chk("rst_rd_en", rd_en_a, 1'b0);
        chk("rst_pkt", pkt_a, 0);
        chk("rst_beat", beats_a, 0);
        chk("rst_busy", busy_a, 1'b0);
        chk("rst_tdata", tdata_a, 0);
        step();
        step();
        axis_resetn = 1'b1;

        // 3-beat packet, latency and swap of literal port values
        gb = got.size();
        push_beats(1, 0, 2, 3);
        chk("lat_before", tvalid_a, 1'b0);
        step();
        chk("lat_after", tvalid_a, 1'b1);
        drain();
        chk("t1_swap_hi", got[gb+1].d[63:48], 16'h04D2);
        chk("t1_swap_lo", got[gb+1].d[47:32], 16'h1234);
        chk("t1_beat0", got[gb].d, mk_beat(1, 0, 3).d);
        chk("t1_beat2", got[gb+2].d, mk_beat(1, 2, 3).d);
        chk("t1_pkt", pkt_a, 1);
        chk("t1_beats", beats_a, 3);

        // backpressure 1,0,0,1,...
        base_b = m_beats;
        nstall = 0;
        rdy_toggle = 1'b1;
        push_beats(2, 0, 3, 4);
        drain();
        rdy_toggle = 1'b0;
        step();
        chk("bp_beats", beats_a, base_b + 4);
        chk("bp_stalled", nstall > 0, 1'b1);

        // 8 back-to-back 2-beat packets
        base_p = m_pkts;
        gb = got.size();
        for (int p = 0; p < 8; p++) push_beats(10 + p, 0, 1, 2);
        nv = 0; first_v = -1; last_v = -1;
        for (int c = 0; c < 22; c++) begin
            step();
            if (tvalid_a) begin
                nv++;
                if (first_v < 0) first_v = c;
                last_v = c;
            end
        end
        chk("b2b_valid_cycles", nv, 16);
        chk("b2b_no_bubble", last_v - first_v + 1, 16);
        chk("b2b_pkts", pkt_a, base_p + 8);
        x = mk_beat(13, 1, 2);
        chk("b2b_swap_pkt3", got[gb+7].d[63:48], x.d[47:32]);

        // single-beat then 2-beat packet
        gb = got.size();
        push_beats(30, 0, 0, 1);
        push_beats(31, 0, 1, 2);
        drain();
        step();
        chk("sb_unmodified", got[gb].d, mk_beat(30, 0, 1).d);
        x = mk_beat(31, 1, 2);
        chk("sb_swap_beat1", got[gb+2].d[47:32], x.d[63:48]);
        chk("sb_busy_end", busy_a, 1'b0);

        // underrun after beat 1 of a 5-beat packet
        gb = got.size();
        push_beats(40, 0, 1, 5);
        for (int c = 0; c < 10; c++) step();
        chk("ur_gap", tvalid_a, 1'b0);
        chk("ur_busy", busy_a, 1'b1);
        push_beats(40, 2, 4, 5);
        drain();
        step();
        chk("ur_beat2", got[gb+2].d, mk_beat(40, 2, 5).d);
        chk("ur_last3", got[gb+3].l, 1'b0);
        chk("ur_last4", got[gb+4].l, 1'b1);

        // asynchronous reset mid-packet
        push_beats(60, 0, 4, 5);
        step();
        step();
        step();
        #2;
        axis_resetn = 1'b0;
        fifo.delete();
        exp_q.delete();
        raw_q.delete();
        m_beats = 0;
        m_pkts  = 0;
        m_inpkt = 1'b0;
        refresh();
        #1;
        chk("arst_tvalid", tvalid_a, 1'b0);
        chk("arst_beat", beats_a, 0);
        chk("arst_pkt", pkt_a, 0);
        chk("arst_busy", busy_a, 1'b0);
        chk("arst_tdata", tdata_a, 0);
        step();
        step();
        axis_resetn = 1'b1;
        gb = got.size();
        push_beats(61, 0, 2, 3);
        drain();
        step();
        x = mk_beat(61, 1, 3);
        chk("arst_swap", got[gb+1].d[63:48], x.d[47:32]);
        chk("arst_beat0", got[gb].d, mk_beat(61, 0, 3).d);
        chk("arst_pkt_after", pkt_a, 1);
        chk("arst_noswap_pkt", pkt_b, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/server_op5_out.md
Name: server_op5_out

Overview:
- Drain stage directly downstream of the op5 server input filter.
- Pops buffered UDP packets from the filter's fall-through packet FIFO and re-emits them as an AXI4-Stream master with full backpressure.
- Swaps the UDP source and destination ports on beat 1 of every packet, turning the request into a server reply.
- Keeps packet and beat statistics counters.

Parameters:
C_M_AXIS_DATA_WIDTH, 256, data width of FIFO words and output stream
C_M_AXIS_TUSER_WIDTH, 128, tuser width of FIFO words and output stream
SWAP_EN, 1, 1 = swap UDP ports on beat 1; 0 = pure pass-through

Ports:
axis_aclk  in  1  clock for all logic
axis_resetn  in  1  reset; asynchronous, active-low
i_pkt_fifo_empty_4  in  1  upstream FIFO empty flag
o_pkt_fifo_rd_en_4  out  1  upstream FIFO pop strobe
i_tdata_fifo_4  in  DATA  FIFO head data; valid whenever empty=0 (fall-through)
i_tuser_fifo_4  in  TUSER  FIFO head tuser
i_tkeep_fifo_4  in  DATA/8  FIFO head tkeep
i_tlast_fifo_4  in  1  FIFO head tlast
m_axis_tdata  out  DATA  output data
m_axis_tkeep  out  DATA/8  output byte enables
m_axis_tuser  out  TUSER  output sideband
m_axis_tvalid  out  1  output valid
m_axis_tready  in  1  downstream ready
m_axis_tlast  out  1  output end of packet
o_pkt_cnt  out  32  packets fully sent (tlast accepted)
o_beat_cnt  out  32  beats accepted downstream
o_busy  out  1  high while a packet is in progress (state != S_HDR)

Behaviour:
- Reset: asynchronous on axis_resetn low. All m_axis_* outputs, o_pkt_fifo_rd_en_4, counters and o_busy are 0; state = S_HDR.
- Output register:
  - m_axis_* is a single registered stage.
  - pop = !i_pkt_fifo_empty_4 && (!m_axis_tvalid || m_axis_tready).
  - o_pkt_fifo_rd_en_4 = pop, combinational.
  - On pop, the output register loads the FIFO head (modified per the swap rule below) and m_axis_tvalid <= 1.
  - Else if m_axis_tready, m_axis_tvalid <= 0.
- Latency: FIFO goes non-empty at cycle N -> m_axis_tvalid high at N+1.
- Throughput: sustained 1 beat/cycle with tready=1 and a non-empty FIFO.
- Payload stability: while m_axis_tvalid=1 and m_axis_tready=0, all m_axis_* hold stable and no pop occurs.
- FSM, advancing on pop only:
  - S_HDR: beat 0, passed unchanged. If its tlast=1 stay in S_HDR (1-beat packet), else -> S_PORT.
  - S_PORT: beat 1. When SWAP_EN=1, output tdata[47:32] = input [63:48] and output [63:48] = input [47:32]; all other bits unchanged. tlast=1 -> S_HDR, else -> S_BODY.
  - S_BODY: beats 2+, passed unchanged; tlast=1 -> S_HDR.
- Counters, updated on the accept condition m_axis_tvalid && m_axis_tready:
  - o_beat_cnt += 1 on every accept.
  - o_pkt_cnt += 1 on every accept with m_axis_tlast=1.
  - Both wrap 0xFFFFFFFF -> 0.
- FIFO underrun mid-packet: no pop and the FSM holds; m_axis_tvalid drops after the current beat is accepted; the packet resumes when the FIFO refills. tvalid gaps inside a packet are legal.
- Simultaneous accept and pop in one cycle: the new beat replaces the old with no bubble, and the counter increments for the old beat.
- Reset mid-packet: the FSM returns to S_HDR immediately. The partial packet is abandoned downstream; the upstream FIFO is reset by the same signal.
- Reads never occur while i_pkt_fifo_empty_4=1.

Test Plan:
- Single packet, 3 beats, tready=1, beat 1 [63:48]=0x1234 and [47:32]=0x04D2 -> output beat 1 has [63:48]=0x04D2 and [47:32]=0x1234; beats 0 and 2 bit-exact; o_pkt_cnt=1, o_beat_cnt=3; first tvalid one cycle after empty falls.
- Backpressure: 4-beat packet with tready toggling 1,0,0,1,… -> no rd_en while valid&&!ready; data stable during stalls; all 4 beats delivered in order; o_beat_cnt=4.
- Back-to-back 2-beat packets ×8 with tready=1 -> 16 consecutive valid cycles, no bubbles; swap applied to beats 1,3,5,…; o_pkt_cnt=8.
- Single-beat packet (tlast on beat 0) followed by a 2-beat packet -> first packet unmodified; swap lands on beat 1 of the second packet; FSM back in S_HDR; o_busy=0 at end.
- Underrun: FIFO empties after beat 1 of a 5-beat packet for 10 cycles -> tvalid gap; beats 2–4 unmodified once the FIFO refills; tlast on beat 4 only.
- Async reset asserted mid-packet between clock edges -> outputs and counters 0 immediately; next packet after reset gets its swap on its own beat 1; SWAP_EN=0 build passes all beats bit-exact.
